dff_pipe_n: RTL

//   Parametrised D-flip-flop pipeline: DEPTH stages of WIDTH-bit registers, each with a valid bit.

---
 rtl/dff_pipe_n.sv | 74 +++++++
 1 files changed

// File: rtl/dff_pipe_n.sv
// rtl/dff_pipe_n.sv - DEPTH-stage WIDTH-bit register pipeline with per-stage valid, stall, flush and occupancy
// Optional per-stage parity and parity_err output when DFF_PIPE_PARITY_EN is defined.
module dff_pipe_n #(
  parameter int unsigned           WIDTH   = 8,
  parameter int unsigned           DEPTH   = 4,
  parameter logic [WIDTH-1:0]      RST_VAL = '0,
  parameter int unsigned           OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
`ifdef DFF_PIPE_PARITY_EN
  output logic             parity_err,
`endif
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [OCC_W-1:0] occ_c;

  // Reset and flush share one path: both empty the pipe and preload RST_VAL.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RST_VAL;
        vld_r[i]  <= 1'b0;
      end
    end else if (en) begin
      data_r[0] <= d;
      vld_r[0]  <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i] <= data_r[i-1];
        vld_r[i]  <= vld_r[i-1];
      end
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_r;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_r[i] <= ^RST_VAL;
      end
    end else if (en) begin
      par_r[0] <= ^d;
      for (int i = 1; i < DEPTH; i++) begin
        par_r[i] <= par_r[i-1];
      end
    end
  end

  assign parity_err = vld_r[DEPTH-1] & ((^data_r[DEPTH-1]) != par_r[DEPTH-1]);
`endif

  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_c = occ_c + OCC_W'(vld_r[i]);
    end
  end

  assign q         = data_r[DEPTH-1];
  assign q_valid   = vld_r[DEPTH-1];
  assign occupancy = occ_c;

endmodule
